// File: rtl/car_sequencer_pkg.sv
// Shared types for the car sensor stimulus generator: phase states and the
// {a,b} pattern tables for each of the four car manoeuvres.
package car_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        GAP  = 3'd4
    } seq_state_e;

    // Element 0 is PH1, element 3 is the closing gap; each entry is {a,b}.
    localparam logic [3:0][1:0] PAT_ENTER      = {2'b00, 2'b01, 2'b11, 2'b10};
    localparam logic [3:0][1:0] PAT_EXIT       = {2'b00, 2'b10, 2'b11, 2'b01};
    localparam logic [3:0][1:0] PAT_BALK_ENTER = {2'b00, 2'b10, 2'b11, 2'b10};
    localparam logic [3:0][1:0] PAT_BALK_EXIT  = {2'b00, 2'b01, 2'b11, 2'b01};

    function automatic logic [1:0] phase_pattern(input logic dir,
                                                 input logic balk,
                                                 input seq_state_e st);
        logic [1:0]       idx;
        logic [3:0][1:0]  tbl;
        idx = 2'd0;
        case (st)
            PH1:     idx = 2'd0;
            PH2:     idx = 2'd1;
            PH3:     idx = 2'd2;
            GAP:     idx = 2'd3;
            default: idx = 2'd0;
        endcase
        case ({dir, balk})
            2'b00:   tbl = PAT_ENTER;
            2'b10:   tbl = PAT_EXIT;
            2'b01:   tbl = PAT_BALK_ENTER;
            default: tbl = PAT_BALK_EXIT;
        endcase
        return (st == IDLE) ? 2'b00 : tbl[idx];
    endfunction

endpackage

// File: rtl/car_sequencer_if.sv
// Command and sensor-output bundle between the sequencer and its driver.
interface car_seq_if;
    logic start;
    logic dir;
    logic balk;
    logic a;
    logic b;
    logic busy;
    logic done;

    modport master (output start, dir, balk, input a, b, busy, done);
    modport slave  (input start, dir, balk, output a, b, busy, done);
endinterface

// File: rtl/car_sequencer_hold_timer.sv
// Phase hold timer: loads HOLD_CYCLES-1, counts down while enabled and
// flags expiry at zero without wrapping.
module hold_timer #(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(HOLD_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);
endmodule

// File: rtl/car_sequencer.sv
// Drives mock photo-sensor lines a/b through enter, exit or balk patterns on
// command so the detector/counter path can be exercised without a real car.
module car_sequencer
    import car_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input logic     clk,
    input logic     reset,
    car_seq_if.slave bus
);
    seq_state_e state_q, state_d;
    logic       dir_q, dir_d;
    logic       balk_q, balk_d;
    logic [1:0] ab_q, ab_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       load;
    logic       expire;

    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .en     (state_q != IDLE),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        balk_d  = balk_q;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = PH1;
                dir_d   = bus.dir;
                balk_d  = bus.balk;
                load    = 1'b1;
            end
            PH1: if (expire) begin
                state_d = PH2;
                load    = 1'b1;
            end
            PH2: if (expire) begin
                state_d = PH3;
                load    = 1'b1;
            end
            PH3: if (expire) begin
                state_d = GAP;
                load    = 1'b1;
            end
            GAP: if (expire) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        ab_d   = phase_pattern(dir_d, balk_d, state_d);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            balk_q  <= 1'b0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            balk_q  <= balk_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.a    = ab_q[1];
    assign bus.b    = ab_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
